data_ram: RTL and testbench

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram.sv | 108 ++++++++++
 tb/tb_data_ram.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// Word-addressed data RAM with a one-entry delayed write buffer.
// Reads are combinational and forward from the buffer; out-of-range writes are dropped and flagged.
module data_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WR_LAT      = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_data_i,
  input  logic        ram_w_request_i,
  output logic [31:0] ram_data_o,
  output logic        stall_req_o,
  output logic        err_o
);
  // state | meaning
  // IDLE  | buffer empty, a write request is captured immediately
  // BUSY  | buffer holds a write; it commits when r_cnt reaches 0

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WR_LAT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_buf_idx;
  logic [31:0]   r_buf_data;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_cnt_zero;
  logic          w_commit;
  logic          w_can_capture;
  logic          w_accept;
  logic [31:0]   w_rd_data;
  logic          w_unused_addr;

  assign w_idx         = ram_addr_i[AW+1:2];
  assign w_in_range    = (ram_addr_i[31:AW+2] == '0);
  assign w_cnt_zero    = (r_cnt == '0);
  assign w_commit      = (r_state == BUSY) && w_cnt_zero;
  assign w_can_capture = (r_state == IDLE) || w_commit;
  assign w_accept      = w_can_capture && ram_w_request_i;
  assign w_unused_addr = ^ram_addr_i[1:0];

  // Only a counting buffer holds the requester off; the commit cycle is free to accept.
  assign stall_req_o = (r_state == BUSY) && !w_cnt_zero && ram_w_request_i;
  assign err_o       = r_err;

  always_comb begin
    w_rd_data = '0;
    if (!rst_n_i || !w_in_range) begin
      w_rd_data = '0;
    end else if ((r_state == BUSY) && (w_idx == r_buf_idx)) begin
      w_rd_data = r_buf_data;
    end else begin
      w_rd_data = r_mem[w_idx];
    end
  end

  assign ram_data_o = w_rd_data;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_buf_idx  <= '0;
      r_buf_data <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_accept && !w_in_range;
      case (r_state)
        IDLE: begin
          if (w_accept && w_in_range) begin
            r_buf_idx  <= w_idx;
            r_buf_data <= ram_data_i;
            r_cnt      <= CNT_LOAD;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_accept && w_in_range) begin
            r_buf_idx  <= w_idx;
            r_buf_data <= ram_data_i;
            r_cnt      <= CNT_LOAD;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Array has no reset; the commit is qualified by the reset-cleared FSM state.
  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      r_mem[r_buf_idx] <= r_buf_data;
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram (WR_LAT=2, DEPTH_WORDS=1024) with hand-computed expectations.
module tb_data_ram;
  localparam int WR_LAT = 2;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] ram_addr_i;
  logic [31:0] ram_data_i;
  logic        ram_w_request_i;
  logic [31:0] ram_data_o;
  logic        stall_req_o;
  logic        err_o;

  int n_chk  = 0;
  int n_pass = 0;

  data_ram #(.DEPTH_WORDS(1024), .WR_LAT(WR_LAT)) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .ram_addr_i      (ram_addr_i),
    .ram_data_i      (ram_data_i),
    .ram_w_request_i (ram_w_request_i),
    .ram_data_o      (ram_data_o),
    .stall_req_o     (stall_req_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] data, input logic req);
    ram_addr_i      = addr;
    ram_data_i      = data;
    ram_w_request_i = req;
  endtask

  // Single accepted write from IDLE, returning once the FSM is back in IDLE.
  task automatic write_full(input logic [31:0] addr, input logic [31:0] data);
    drive(addr, data, 1'b1);
    tick();
    ram_w_request_i = 1'b0;
    repeat (WR_LAT) tick();
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    ram_addr_i = addr;
    settle();
    chk(tag, ram_data_o, exp);
  endtask

  initial begin
    rst_n_i = 1'b0;
    drive(32'h10, 32'h0, 1'b1);
    settle();
    chk("rst_stall", {31'b0, stall_req_o}, 32'h0);
    chk("rst_err", {31'b0, err_o}, 32'h0);
    chk("rst_rdata", ram_data_o, 32'h0);
    ram_w_request_i = 1'b0;
    tick();
    rst_n_i = 1'b1;

    // single write, forwarding then array
    drive(32'h10, 32'hDEADBEEF, 1'b1);
    settle();
    chk("w1_stall_c0", {31'b0, stall_req_o}, 32'h0);
    tick();
    ram_w_request_i = 1'b0;
    read_chk("w1_fwd_c1", 32'h10, 32'hDEADBEEF);
    tick();
    settle();
    chk("w1_stall_c2", {31'b0, stall_req_o}, 32'h0);
    tick();
    read_chk("w1_array_c3", 32'h10, 32'hDEADBEEF);

    // second request held while buffer counts, accepted in the commit cycle
    drive(32'h10, 32'h11111111, 1'b1);
    settle();
    chk("w2_stall_c0", {31'b0, stall_req_o}, 32'h0);
    tick();
    drive(32'h14, 32'h22222222, 1'b1);
    settle();
    chk("w2_stall_c1", {31'b0, stall_req_o}, 32'h1);
    tick();
    settle();
    chk("w2_stall_c2", {31'b0, stall_req_o}, 32'h0);
    tick();
    ram_w_request_i = 1'b0;
    read_chk("w2_fwd_14", 32'h14, 32'h22222222);
    read_chk("w2_arr_10", 32'h10, 32'h11111111);
    tick();
    tick();
    read_chk("w2_final_10", 32'h10, 32'h11111111);
    read_chk("w2_final_14", 32'h14, 32'h22222222);

    // forwarding hits only the buffered word
    write_full(32'h24, 32'h5A5A0024);
    write_full(32'h20, 32'hAABBCCDD);
    read_chk("fw_pre_20", 32'h20, 32'hAABBCCDD);
    drive(32'h20, 32'hAABBCC55, 1'b1);
    tick();
    ram_w_request_i = 1'b0;
    read_chk("fw_busy_20", 32'h20, 32'hAABBCC55);
    read_chk("fw_busy_24", 32'h24, 32'h5A5A0024);
    tick();
    tick();
    read_chk("fw_after_20", 32'h20, 32'hAABBCC55);

    // out-of-range write in IDLE; 0x1000 aliases word 0 in its low bits
    write_full(32'h0, 32'hCAFE0000);
    drive(32'h1000, 32'hFFFFFFFF, 1'b1);
    settle();
    chk("oor_stall", {31'b0, stall_req_o}, 32'h0);
    chk("oor_err_c0", {31'b0, err_o}, 32'h0);
    chk("oor_rd_1000", ram_data_o, 32'h0);
    tick();
    ram_w_request_i = 1'b0;
    settle();
    chk("oor_err_c1", {31'b0, err_o}, 32'h1);
    tick();
    settle();
    chk("oor_err_c2", {31'b0, err_o}, 32'h0);
    read_chk("oor_word0", 32'h0, 32'hCAFE0000);
    read_chk("oor_rd_again", 32'h1000, 32'h0);

    // out-of-range write held during BUSY: stall, then error on acceptance
    drive(32'h50, 32'h00000050, 1'b1);
    tick();
    drive(32'h1000, 32'h77777777, 1'b1);
    settle();
    chk("oorb_stall_c1", {31'b0, stall_req_o}, 32'h1);
    chk("oorb_err_c1", {31'b0, err_o}, 32'h0);
    tick();
    settle();
    chk("oorb_stall_c2", {31'b0, stall_req_o}, 32'h0);
    chk("oorb_err_c2", {31'b0, err_o}, 32'h0);
    tick();
    ram_w_request_i = 1'b0;
    settle();
    chk("oorb_err_c3", {31'b0, err_o}, 32'h1);
    read_chk("oorb_50", 32'h50, 32'h00000050);
    read_chk("oorb_word0", 32'h0, 32'hCAFE0000);
    tick();
    settle();
    chk("oorb_err_c4", {31'b0, err_o}, 32'h0);

    // reset discards a pending write and forces outputs
    write_full(32'h30, 32'h0);
    drive(32'h30, 32'h12345678, 1'b1);
    tick();
    rst_n_i = 1'b0;
    drive(32'h10, 32'h0, 1'b1);
    settle();
    chk("rst2_rdata", ram_data_o, 32'h0);
    chk("rst2_stall", {31'b0, stall_req_o}, 32'h0);
    chk("rst2_err", {31'b0, err_o}, 32'h0);
    tick();
    tick();
    rst_n_i = 1'b1;
    ram_w_request_i = 1'b0;
    read_chk("rst2_rd_30", 32'h30, 32'h0);
    chk("rst2_stall_rel", {31'b0, stall_req_o}, 32'h0);
    chk("rst2_err_rel", {31'b0, err_o}, 32'h0);
    tick();
    tick();
    read_chk("rst2_rd_30_late", 32'h30, 32'h0);
    read_chk("rst2_keep_10", 32'h10, 32'h11111111);

    // back-to-back writes to the same word
    drive(32'h40, 32'h1, 1'b1);
    settle();
    chk("same_stall_c0", {31'b0, stall_req_o}, 32'h0);
    tick();
    drive(32'h40, 32'h2, 1'b1);
    settle();
    chk("same_stall_c1", {31'b0, stall_req_o}, 32'h1);
    chk("same_fwd_c1", ram_data_o, 32'h1);
    tick();
    settle();
    chk("same_stall_c2", {31'b0, stall_req_o}, 32'h0);
    tick();
    ram_w_request_i = 1'b0;
    read_chk("same_fwd_c3", 32'h40, 32'h2);
    tick();
    tick();
    read_chk("same_final", 32'h40, 32'h2);
    read_chk("same_neighbor", 32'h24, 32'h5A5A0024);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
